// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family (sync and async variants):
// address, pointer and occupancy width derivation.
package fifo_pkg;

    localparam int FIFO_MIN_ADDR_WIDTH = 1;

    typedef enum logic {
        RD_MODE_STD  = 1'b0,
        RD_MODE_FWFT = 1'b1
    } rd_mode_e;

    function automatic int addr_width_f(input int depth);
        return ($clog2(depth) > FIFO_MIN_ADDR_WIDTH) ? $clog2(depth) : FIFO_MIN_ADDR_WIDTH;
    endfunction

    // Pointers carry one extra wrap bit to tell full from empty.
    function automatic int ptr_width_f(input int depth);
        return addr_width_f(depth) + 1;
    endfunction

    // Occupancy must represent 0..depth inclusive.
    function automatic int level_width_f(input int depth);
        return addr_width_f(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_dpram.sv
// Simple dual-port RAM, one write and one read port on a single clock.
// REG_RD=1 gives a registered read (output reset to 0); REG_RD=0 a combinational read.
module sync_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4,
    parameter bit REG_RD     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; only pointers and flags define
    // validity, and a reset on the array would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (REG_RD) begin : g_reg_rd
            logic [DATA_WIDTH-1:0] rd_data_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_data_q <= '0;
                end else if (rd_en) begin
                    rd_data_q <= mem[rd_addr];
                end
            end

            assign rd_data = rd_data_q;
        end else begin : g_comb_rd
            logic unused_ok;
            assign unused_ok = &{1'b0, rst_n, rd_en};
            assign rd_data   = mem[rd_addr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level, almost-full/almost-empty flags and
// optional FWFT read. Define SYNC_FIFO_ERR_EN to build sticky overflow/underflow flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_AFULL  = FIFO_DEPTH - 1,
    parameter int FIFO_AEMPTY = 1,
    parameter int FWFT        = 0,
    localparam int ADDR_WIDTH = addr_width_f(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int       PW      = ptr_width_f(FIFO_DEPTH);
    localparam int       LW      = level_width_f(FIFO_DEPTH);
    localparam rd_mode_e RD_MODE = (FWFT != 0) ? RD_MODE_FWFT : RD_MODE_STD;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_q, level_nxt;
    logic          full_q, empty_q, afull_q, aempty_q;
    logic          wr_vld, rd_vld;

    // Requests against a full/empty FIFO are dropped, so full+wr+rd pops only
    // and empty+wr+rd pushes only.
    assign wr_vld = wr_en & ~full_q;
    assign rd_vld = rd_en & ~empty_q;

    // NOTE: every variable assigned in always_comb gets its default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        level_nxt = level_q;
        level_nxt = level_nxt + LW'(wr_vld) - LW'(rd_vld);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_vld) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level_q  <= level_nxt;
            full_q   <= (level_nxt == LW'(FIFO_DEPTH));
            empty_q  <= (level_nxt == '0);
            afull_q  <= (level_nxt >= LW'(FIFO_AFULL));
            aempty_q <= (level_nxt <= LW'(FIFO_AEMPTY));
        end
    end

    sync_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_RD     (RD_MODE == RD_MODE_STD)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_vld),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_vld),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    generate
        if (RD_MODE == RD_MODE_STD) begin : g_std_valid
            logic rd_valid_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_vld;
                end
            end

            assign rd_valid = rd_valid_q;
        end else begin : g_fwft_valid
            // The head word is on rd_data whenever anything is stored.
            assign rd_valid = ~empty_q;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign level  = level_q;
    assign full   = full_q;
    assign empty  = empty_q;
    assign afull  = afull_q;
    assign aempty = aempty_q;

endmodule
